spi_master_ctrl: RTL and testbench

//  Single-word full-duplex SPI master, all four CPOL/CPHA modes. A start pulse launches one

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_master_ctrl_sclk_gen.sv | 82 ++++++++
 rtl/spi_master_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// ----------------------------------------------------------------------------
// spi_master_pkg
// Shared types and helpers for the SPI master controller.
//   state_e    : transfer FSM states (IDLE -> XFER -> DONE -> IDLE)
//   half_div   : sclk half-period in system clocks, floored, never below 1
//   edge_cnt_w : width of a counter that holds 0 .. 2*data_width sclk toggles
// ----------------------------------------------------------------------------
package spi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int half_div(input int clk_f, input int spi_f);
    int h;
    h = clk_f / (2 * spi_f);
    return (h < 1) ? 1 : h;
  endfunction

  function automatic int edge_cnt_w(input int data_width);
    return $clog2(2 * data_width + 1);
  endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// ----------------------------------------------------------------------------
// spi_sclk_gen
// Half-period timer and sclk generator for one SPI transfer.
//   clk, rst   : system clock, asynchronous active-high reset
//   clear      : restart timer and edge count, sclk back to idle level
//   en         : timer runs while high (transfer in progress)
//   sclk       : generated SPI clock
//   half_stb   : one-cycle strobe at every half-period expiry
//   lead_stb   : this cycle's expiry toggles a leading (odd) sclk edge
//   trail_stb  : this cycle's expiry toggles a trailing (even) sclk edge
//   last_edge  : all 2*DATA_WIDTH toggles have been issued
//   pair_idx   : 0-based bit index of the current leading/trailing pair
// ----------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int HALF       = 5,
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b1,
  parameter int ECW        = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  output logic           sclk,
  output logic           half_stb,
  output logic           lead_stb,
  output logic           trail_stb,
  output logic           last_edge,
  output logic [ECW-1:0] pair_idx
);

  localparam int             CW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(HALF - 1);
  localparam logic [ECW-1:0] EDGE_TOT = ECW'(2 * DATA_WIDTH);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [ECW-1:0] edge_cnt_q, edge_cnt_d;
  logic           sclk_q, sclk_d;
  logic           toggle;

  always_comb begin
    half_stb   = en && (cnt_q == CNT_MAX);
    last_edge  = (edge_cnt_q == EDGE_TOT);
    // Once every toggle is issued, expiries only time the cs hold period.
    toggle     = half_stb && !last_edge;
    // edge_cnt_q counts toggles already done, so an even count means the
    // next toggle is odd-numbered, i.e. a leading edge.
    lead_stb   = toggle && !edge_cnt_q[0];
    trail_stb  = toggle &&  edge_cnt_q[0];
    pair_idx   = edge_cnt_q >> 1;

    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    if (clear) begin
      cnt_d      = '0;
      edge_cnt_d = '0;
      sclk_d     = CPOL;
    end else if (en) begin
      cnt_d = half_stb ? '0 : cnt_q + 1'b1;
      if (toggle) begin
        sclk_d     = ~sclk_q;
        edge_cnt_d = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= CPOL;
    end else begin
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl
// Single-word full-duplex SPI master supporting all CPOL/CPHA modes.
// A start pulse in IDLE launches one DATA_WIDTH-bit transfer, MSB first.
//   clk       : system clock
//   rst       : asynchronous active-high reset (aborts any transfer)
//   data_in   : word to send, latched when start is accepted
//   start     : one-cycle request, ignored unless idle
//   miso      : serial data from slave
//   sclk      : SPI clock, idles at CPOL
//   cs_n      : active-low chip select
//   mosi      : serial data to slave
//   finish    : one-cycle pulse when the transfer completes
//   data_out  : last received word, held until the next finish
// Build option: SPI_MASTER_LOOPBACK_EN samples the internal mosi instead of
// miso, so data_out returns the transmitted word; miso is then ignored.
// ----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int SPI_FREQUENCE = 5_000_000,
  parameter int DATA_WIDTH    = 8,
  parameter bit CPOL          = 1'b1,
  parameter bit CPHA          = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  output logic                  finish,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int HALF = half_div(CLK_FREQUENCE, SPI_FREQUENCE);
  localparam int ECW  = edge_cnt_w(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  finish_q, finish_d;

  logic                  accept;
  logic                  half_stb, lead_stb, trail_stb, last_edge;
  logic [ECW-1:0]        pair_idx;
  logic                  sample_en, shift_en, rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = miso;
`endif

  assign accept = (state_q == ST_IDLE) && start;

  spi_sclk_gen #(
    .HALF       (HALF),
    .DATA_WIDTH (DATA_WIDTH),
    .CPOL       (CPOL),
    .ECW        (ECW)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .en        (state_q == ST_XFER),
    .sclk      (sclk),
    .half_stb  (half_stb),
    .lead_stb  (lead_stb),
    .trail_stb (trail_stb),
    .last_edge (last_edge),
    .pair_idx  (pair_idx)
  );

  always_comb begin
    // CPHA=0: sample leading, shift on trailing edges except the last.
    // CPHA=1: sample trailing, shift on leading edges except the first.
    sample_en = CPHA ? trail_stb : lead_stb;
    shift_en  = CPHA ? (lead_stb  && (pair_idx != '0))
                     : (trail_stb && (pair_idx < ECW'(DATA_WIDTH - 1)));

    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    finish_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d    = data_in;
          rx_d    = '0;
          mosi_d  = data_in[DATA_WIDTH-1];
          cs_n_d  = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (sample_en) rx_d = {rx_q[DATA_WIDTH-2:0], rx_bit};
        if (shift_en) begin
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          mosi_d = tx_q[DATA_WIDTH-2];
        end
        // Expiry after the final toggle ends the cs hold time.
        if (half_stb && last_edge) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          finish_d   = 1'b1;
          data_out_d = rx_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      finish_q   <= finish_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;
  assign finish   = finish_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Four masters, one per SPI mode, each talking to a behavioural slave that
// shifts out a chosen word and records what it sees on mosi.
//   instance 0: CPOL=1 CPHA=1   instance 1: CPOL=0 CPHA=0
//   instance 2: CPOL=0 CPHA=1   instance 3: CPOL=1 CPHA=0
// ----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  localparam bit [3:0] POL_V = 4'b1001;
  localparam bit [3:0] PHA_V = 4'b0101;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = 4'b0;
  logic [3:0] miso_v = 4'b0;
  logic [7:0] din [4];
  logic [3:0] sclk_w, cs_n_w, mosi_w, fin_w;
  logic [7:0] dout_w [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_ctrl #(
      .CLK_FREQUENCE (50_000_000),
      .SPI_FREQUENCE (5_000_000),
      .DATA_WIDTH    (8),
      .CPOL          (POL_V[g]),
      .CPHA          (PHA_V[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (din[g]),
      .start    (start_v[g]),
      .miso     (miso_v[g]),
      .sclk     (sclk_w[g]),
      .cs_n     (cs_n_w[g]),
      .mosi     (mosi_w[g]),
      .finish   (fin_w[g]),
      .data_out (dout_w[g])
    );
  end

  // Behavioural slaves: word to return, shift state, captured mosi, toggles.
  logic [7:0] s_word [4];
  logic [7:0] s_tx   [4];
  logic [7:0] s_rx   [4];
  int         tog    [4];
  logic [3:0] sclk_prev = 4'b0;
  logic [3:0] cs_prev   = 4'hF;

  always @(sclk_w or cs_n_w) begin
    for (int g = 0; g < 4; g++) begin
      if (cs_prev[g] && !cs_n_w[g]) begin
        s_tx[g] = s_word[g];
        s_rx[g] = 8'h00;
        tog[g]  = 0;
        if (!PHA_V[g]) miso_v[g] = s_tx[g][7];
      end else if (!cs_n_w[g] && (sclk_w[g] != sclk_prev[g])) begin
        tog[g] = tog[g] + 1;
        if ((sclk_w[g] != POL_V[g]) != PHA_V[g]) begin
          s_rx[g] = {s_rx[g][6:0], mosi_w[g]};
        end else if (PHA_V[g]) begin
          miso_v[g] = s_tx[g][7];
          s_tx[g]   = {s_tx[g][6:0], 1'b0};
        end else begin
          s_tx[g]   = {s_tx[g][6:0], 1'b0};
          miso_v[g] = s_tx[g][7];
        end
      end
    end
    sclk_prev = sclk_w;
    cs_prev   = cs_n_w;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sw);
    return LOOPBACK ? tx : sw;
  endfunction

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start_v[g] = 1'b1;
    @(posedge clk); #1 start_v[g] = 1'b0;
  endtask

  // Watch on falling edges; counts cs_n low cycles and finish pulses.
  task automatic watch(input int g, input int max_cyc, input bit stop_on_fin,
                       output int cs_low, output int fins);
    cs_low = 0;
    fins   = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!cs_n_w[g]) cs_low++;
      if (fin_w[g]) begin
        fins++;
        if (stop_on_fin) break;
      end
    end
  endtask

  task automatic xfer(input string tag, input int g, input logic [7:0] tx,
                      input logic [7:0] sw, input bit disturb);
    int cs_low, fins, extra_low, extra_fins;
    din[g]    = tx;
    s_word[g] = sw;
    pulse_start(g);
    fork
      watch(g, 300, 1'b1, cs_low, fins);
      begin
        if (disturb) begin
          repeat (20) @(posedge clk);
          #1 din[g] = 8'hFF;
          start_v[g] = 1'b1;
          @(posedge clk); #1 start_v[g] = 1'b0;
        end
      end
    join
    chk({tag, "_finish"}, fins, 1);
    chk({tag, "_mosi_word"}, s_rx[g], tx);
    chk({tag, "_data_out"}, dout_w[g], exp_rx(tx, sw));
    chk({tag, "_toggles"}, tog[g], 16);
    chk({tag, "_cs_low"}, cs_low, 85);
    chk({tag, "_idle"}, {sclk_w[g], cs_n_w[g], mosi_w[g]}, {POL_V[g], 1'b1, 1'b0});
    if (disturb) begin
      watch(g, 120, 1'b0, extra_low, extra_fins);
      chk({tag, "_no_extra_finish"}, extra_fins, 0);
      chk({tag, "_no_extra_cs"}, extra_low, 0);
    end
  endtask

  initial begin
    int cs_low, fins;
    for (int g = 0; g < 4; g++) begin
      din[g]    = 8'h00;
      s_word[g] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++)
      chk($sformatf("reset_state_%0d", g),
          {sclk_w[g], cs_n_w[g], mosi_w[g], fin_w[g], dout_w[g]},
          {POL_V[g], 1'b1, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;

    // Mode 11 with A5 / 3C
    xfer("m11", 0, 8'hA5, 8'h3C, 1'b0);
    // Remaining modes with 9A / C3
    xfer("m00", 1, 8'h9A, 8'hC3, 1'b0);
    xfer("m01", 2, 8'h9A, 8'hC3, 1'b0);
    xfer("m10", 3, 8'h9A, 8'hC3, 1'b0);

    // Back-to-back: second start in the cycle after finish
    xfer("b2b_a", 0, 8'hA5, 8'h3C, 1'b0);
    xfer("b2b_b", 0, 8'h9A, 8'h66, 1'b0);

    // start and data_in changed mid-transfer must be ignored
    xfer("busy", 0, 8'hA5, 8'h3C, 1'b1);

    // Asynchronous reset after the 4th sclk toggle
    din[0]    = 8'hA5;
    s_word[0] = 8'h3C;
    pulse_start(0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tog[0] >= 4) break;
    end
    chk("rst_reached_4_toggles", tog[0], 4);
    #2 rst = 1'b1;
    #1;
    chk("rst_abort_outputs", {sclk_w[0], cs_n_w[0], mosi_w[0], fin_w[0], dout_w[0]},
        {POL_V[0], 1'b1, 1'b0, 1'b0, 8'h00});
    @(posedge clk); #1 rst = 1'b0;
    watch(0, 120, 1'b0, cs_low, fins);
    chk("rst_no_finish", fins, 0);
    xfer("after_rst", 0, 8'h5A, 8'hC3, 1'b0);

    // miso held at 0: loopback build still returns the transmitted word
    xfer("miso_zero", 0, 8'h5A, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
